clkdiv_ratio_ctrl: RTL and testbench
====================================

Name: clkdiv_ratio_ctrl

Overview:
Run-time controller for the even-ratio clock divider family. It owns one programmable even divider, with divide ratio = 2*half, and accepts ratio-change requests over a valid/ready handshake. It applies each accepted change only at a falling edge of the divided output, so the output never produces a runt pulse. It sits between the configuration logic and the divided-clock consumers, replacing hard-wired fixed-ratio dividers.

Parameters:
CNT_W, 8, width of the half-period count and of the request field.
DEFAULT_HALF, 1, half-period in clk cycles after reset (1 = div2). Must be nonzero; elaboration fails if it is 0.

Ports:
clk  input  1  system clock; all logic on posedge.
resetn  input  1  asynchronous, active-low reset.
req_valid  input  1  ratio-change request valid.
req_half  input  CNT_W  requested half-period in clk cycles; ratio = 2*req_half.
req_ready  output  1  controller can accept a request.
div_out  output  1  divided clock output, registered.
div_rise  output  1  one-cycle pulse, registered, high in the cycle div_out goes 0->1.
cur_half  output  CNT_W  half-period currently in effect.
busy  output  1  change pending (state != IDLE).
err  output  1  one-cycle pulse: request with req_half==0 rejected.

Behaviour:
- Reset values: count=0, div_out=0, div_rise=0, cur_half=DEFAULT_HALF, state=IDLE, req_ready=1, busy=0, err=0. Any pending half is discarded.
- Divider core:
  - count increments each cycle.
  - When count==cur_half-1 (terminal count, TC): count<=0 and div_out<=~div_out.
  - div_rise<=1 on the TC cycle where div_out is 0; otherwise 0.
  - div_out is high for exactly cur_half cycles and low for cur_half cycles.
- FSM states: IDLE, WAIT_FALL.
- IDLE: req_ready=1. A request is accepted on the cycle where req_valid && req_ready.
  - req_half==0: err=1 the next cycle; no state or ratio change; stay IDLE.
  - req_half==cur_half: accepted as a no-op; stay IDLE; no err.
  - Otherwise: pending<=req_half; go to WAIT_FALL.
- WAIT_FALL: req_ready=0, busy=1. Wait for a TC cycle with div_out==1 (the falling edge). On that cycle:
  - div_out<=0, count<=0, cur_half<=pending, state<=IDLE.
  - The first low phase already uses the new half.
  - TC cycles with div_out==0 toggle normally and do not switch the ratio.
- Switch latency from acceptance: at most 2*cur_half_old cycles. If accepted during a high phase, the switch occurs at the end of that phase.
- Phase rules: the old ratio's high phase is never truncated. There are never two consecutive toggles closer than min(old, new) half.
- A request held during WAIT_FALL stays unaccepted until IDLE; req_valid is sampled again then.
- Back-to-back requests: a new request can be accepted in the first IDLE cycle after a switch.
- Reset asserted mid-WAIT_FALL: pending change is lost; outputs go to reset values immediately (asynchronous).
- Arithmetic: count is CNT_W bits and is compared against cur_half-1. cur_half is always >= 1, so there is no underflow. The maximum ratio is 2*(2^CNT_W - 1).

Decomposition:
- clkdiv_pkg:
  - state enum type ctrl_state_e {IDLE, WAIT_FALL}.
  - Localparam CNT_W_DEFAULT=8.
- Sub-module even_div_core (count, div_out, div_rise, TC output). Inputs: half and a synchronous load strobe that forces count=0 and div_out=0.
- clkdiv_ratio_ctrl holds the FSM, the pending register and the handshake.

Test Plan:
1. Reset release, no requests -> cur_half=1, div_out toggles every clk (div2); div_rise pulses every 2nd cycle.
2. From half=1, request half=3 -> accepted; switch at the next falling edge; then div_out is 3 high / 3 low (div6) continuously; busy high only between acceptance and the switch.
3. From half=3, accept half=2 on the first high cycle -> high phase lasts the full 3 cycles, then low=2 and high=2 (div4). Latency from acceptance to switch is 3 cycles.
4. Request req_half=0 -> err pulses once, cur_half unchanged, div_out period unchanged. Request half equal to cur_half -> no busy, no err.
5. req_valid held high with half=5 during WAIT_FALL of a prior half=2 request -> req_ready=0 until the switch. Half=5 is accepted in the first IDLE cycle and applied at the following falling edge.
6. Assert resetn low mid-WAIT_FALL -> div_out=0 and cur_half=DEFAULT_HALF asynchronously. After release, div2 resumes and the pending change never applies.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the run-time programmable even clock divider.
package clkdiv_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_FALL = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/even_div_core.sv
// Even divider: div_out spends half cycles high and half cycles low.
// load restarts the waveform at the beginning of a low phase.
module even_div_core
    import clkdiv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [CNT_W-1:0] half,
    input  logic             load,
    output logic             div_out,
    output logic             div_rise,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    // half is never zero, so half-1 cannot wrap.
    assign tc = (count == half - CNT_W'(1));

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count    <= '0;
            div_out  <= 1'b0;
            div_rise <= 1'b0;
        end else if (load) begin
            count    <= '0;
            div_out  <= 1'b0;
            div_rise <= 1'b0;
        end else if (tc) begin
            count    <= '0;
            div_out  <= ~div_out;
            div_rise <= ~div_out;
        end else begin
            count    <= count + CNT_W'(1);
            div_rise <= 1'b0;
        end
    end

endmodule

// File: rtl/clkdiv_ratio_ctrl.sv
// Ratio-change controller: accepts a new half-period over valid/ready and
// applies it only at a falling edge of div_out so no runt pulse is produced.
module clkdiv_ratio_ctrl
    import clkdiv_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int DEFAULT_HALF = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    input  logic [CNT_W-1:0] req_half,
    output logic             req_ready,
    output logic             div_out,
    output logic             div_rise,
    output logic [CNT_W-1:0] cur_half,
    output logic             busy,
    output logic             err
);

    if (DEFAULT_HALF == 0) begin : g_bad_default
        $error("DEFAULT_HALF must be nonzero");
    end

    ctrl_state_e      state, state_next;
    logic [CNT_W-1:0] pending, pending_next;
    logic [CNT_W-1:0] cur_half_next;
    logic             tc;
    logic             accept;
    logic             switch_now;

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = req_valid && req_ready;
    assign switch_now = (state == WAIT_FALL) && tc && div_out;

    even_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk      (clk),
        .resetn   (resetn),
        .half     (cur_half),
        .load     (switch_now),
        .div_out  (div_out),
        .div_rise (div_rise),
        .tc       (tc)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next    = state;
        pending_next  = pending;
        cur_half_next = cur_half;
        case (state)
            IDLE: begin
                if (accept && (req_half != '0) && (req_half != cur_half)) begin
                    pending_next = req_half;
                    state_next   = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                if (switch_now) begin
                    cur_half_next = pending;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            pending  <= '0;
            cur_half <= CNT_W'(DEFAULT_HALF);
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            pending  <= pending_next;
            cur_half <= cur_half_next;
            err      <= accept && (req_half == '0);
        end
    end

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// Self-checking bench: per-cycle scoreboard against a behavioural model,
// a table of ratio-change requests, and hand-written corner-case sequences.
module tb_clkdiv_ratio_ctrl;

    typedef struct packed {
        logic       div_out;
        logic       div_rise;
        logic [7:0] cur_half;
        logic       busy;
        logic       req_ready;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] half;
        logic       exp_err;
        logic       exp_busy;
        logic [7:0] exp_half;
        int         exp_hi;
        int         exp_lo;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req_valid;
    logic [7:0] req_half;
    logic       req_ready;
    logic       div_out;
    logic       div_rise;
    logic [7:0] cur_half;
    logic       busy;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t sb_q[$];

    // behavioural model state
    logic [7:0] m_count, m_half, m_pend;
    logic       m_div, m_rise, m_state, m_err;

    clkdiv_ratio_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_half  (req_half),
        .req_ready (req_ready),
        .div_out   (div_out),
        .div_rise  (div_rise),
        .cur_half  (cur_half),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_count = 8'd0;
        m_half  = 8'd1;
        m_pend  = 8'd0;
        m_div   = 1'b0;
        m_rise  = 1'b0;
        m_state = 1'b0;
        m_err   = 1'b0;
    endtask

    // Advance one clock: predict post-edge outputs, then compare after the edge.
    task automatic step();
        exp_t e, a;
        logic acc, last;
        if (!resetn) begin
            m_reset();
        end else begin
            acc   = req_valid && !m_state;
            last  = (m_count == m_half - 8'd1);
            m_err = acc && (req_half == 8'd0);
            if (!m_state) begin
                if (acc && req_half != 8'd0 && req_half != m_half) begin
                    m_pend  = req_half;
                    m_state = 1'b1;
                end
            end else if (last && m_div) begin
                m_half  = m_pend;
                m_state = 1'b0;
            end
            m_rise  = last && !m_div;
            m_div   = last ? ~m_div : m_div;
            m_count = last ? 8'd0 : m_count + 8'd1;
        end
        e = '{div_out: m_div, div_rise: m_rise, cur_half: m_half,
              busy: m_state, req_ready: !m_state, err: m_err};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        a = '{div_out: div_out, div_rise: div_rise, cur_half: cur_half,
              busy: busy, req_ready: req_ready, err: err};
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("cycle_outputs", 32'(a), 32'(e));
        end
    endtask

    task automatic request(input logic [7:0] h);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_half  = h;
        while (!req_ready && n < 100) begin
            step();
            n++;
        end
        check("req_ready_before_accept", 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 600) begin
            step();
            n++;
        end
        check("switch_within_budget", 32'(busy), 0);
    endtask

    task automatic wait_rise();
        int n;
        n = 0;
        while (!div_rise && n < 600) begin
            step();
            n++;
        end
        check("rise_within_budget", 32'(div_rise), 1);
    endtask

    task automatic measure(input int exp_hi, input int exp_lo, input string tag);
        int n, hi, lo;
        n = 0;
        hi = 0;
        lo = 0;
        wait_rise();
        while (div_out && n < 600) begin
            hi++;
            step();
            n++;
        end
        while (!div_out && n < 600) begin
            lo++;
            step();
            n++;
        end
        check({tag, "_high"}, 32'(hi), 32'(exp_hi));
        check({tag, "_low"}, 32'(lo), 32'(exp_lo));
    endtask

    vec_t vecs[5];

    initial begin
        int lat, hi, lo;

        vecs[0] = '{half: 8'd3, exp_err: 1'b0, exp_busy: 1'b1, exp_half: 8'd3, exp_hi: 3, exp_lo: 3};
        vecs[1] = '{half: 8'd0, exp_err: 1'b1, exp_busy: 1'b0, exp_half: 8'd3, exp_hi: 3, exp_lo: 3};
        vecs[2] = '{half: 8'd3, exp_err: 1'b0, exp_busy: 1'b0, exp_half: 8'd3, exp_hi: 3, exp_lo: 3};
        vecs[3] = '{half: 8'd4, exp_err: 1'b0, exp_busy: 1'b1, exp_half: 8'd4, exp_hi: 4, exp_lo: 4};
        vecs[4] = '{half: 8'd1, exp_err: 1'b0, exp_busy: 1'b1, exp_half: 8'd1, exp_hi: 1, exp_lo: 1};

        resetn    = 1'b0;
        req_valid = 1'b0;
        req_half  = 8'd0;
        m_reset();
        #12;
        check("rst_div_out", 32'(div_out), 0);
        check("rst_div_rise", 32'(div_rise), 0);
        check("rst_cur_half", 32'(cur_half), 1);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // div2 after reset
        for (int i = 0; i < 3; i++) measure(1, 1, "div2");

        // table of requests
        for (int i = 0; i < 5; i++) begin
            request(vecs[i].half);
            check("vec_err", 32'(err), 32'(vecs[i].exp_err));
            check("vec_busy", 32'(busy), 32'(vecs[i].exp_busy));
            wait_idle();
            check("vec_cur_half", 32'(cur_half), 32'(vecs[i].exp_half));
            measure(vecs[i].exp_hi, vecs[i].exp_lo, "vec_period");
            measure(vecs[i].exp_hi, vecs[i].exp_lo, "vec_period");
        end

        // accept half=2 on the first high cycle of half=3
        request(8'd3);
        wait_idle();
        wait_rise();
        req_valid = 1'b1;
        req_half  = 8'd2;
        step();
        req_valid = 1'b0;
        lat = 1;
        hi  = 1;
        while (cur_half != 8'd2 && lat < 50) begin
            hi += 32'(div_out);
            step();
            lat++;
        end
        check("hi_to_lo_latency", 32'(lat), 3);
        check("old_high_untruncated", 32'(hi), 3);
        lo = 0;
        while (!div_out && lo < 50) begin
            lo++;
            step();
        end
        check("first_new_low", 32'(lo), 2);
        measure(2, 2, "div4");

        // request held through WAIT_FALL
        request(8'd4);
        wait_idle();
        req_valid = 1'b1;
        req_half  = 8'd2;
        step();
        check("held_busy", 32'(busy), 1);
        req_half = 8'd5;
        check("held_ready_low", 32'(req_ready), 0);
        wait_idle();
        check("held_first_idle_half", 32'(cur_half), 2);
        check("held_first_idle_ready", 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
        check("held_accepted", 32'(busy), 1);
        lat = 0;
        while (busy && lat < 50) begin
            step();
            lat++;
        end
        check("held_latency_bound", 32'(lat <= 4), 1);
        check("held_cur_half", 32'(cur_half), 5);
        measure(5, 5, "div10");

        // asynchronous reset during WAIT_FALL
        wait_rise();
        req_valid = 1'b1;
        req_half  = 8'd3;
        step();
        req_valid = 1'b0;
        step();
        check("pre_reset_busy", 32'(busy), 1);
        #3;
        resetn = 1'b0;
        #1;
        m_reset();
        check("async_div_out", 32'(div_out), 0);
        check("async_cur_half", 32'(cur_half), 1);
        check("async_busy", 32'(busy), 0);
        check("async_req_ready", 32'(req_ready), 1);
        step();
        step();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) measure(1, 1, "post_reset_div2");
        for (int i = 0; i < 12; i++) step();
        check("pending_discarded", 32'(cur_half), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
